// File: rtl/draw_scheduler.sv
// Arbitrates eight draw requesters and rasterises the winner's region to a VGA pixel port.
// Define DRAW_SCHED_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module draw_scheduler #(
    parameter logic [7:0] SPRITE_W = 8'd32,
    parameter logic [6:0] SPRITE_H = 7'd32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] req,
    input  logic [7:0] org_x,
    input  logic [6:0] org_y,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       plot,
    output logic [7:0] x_data,
    output logic [6:0] y_data,
    output logic [7:0] done
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam logic [XW-1:0] SCR_W = 8'd160;
    localparam logic [YW-1:0] SCR_H = 7'd120;

    typedef enum logic [1:0] {IDLE, GRANT, SCAN, DONE} state_t;

    state_t        state;
    logic [XW-1:0] ox, w, cx;
    logic [YW-1:0] oy, h, cy;

    logic [2:0]    win;
    logic          col_end, last, vis;
    logic [XW-1:0] ncx, tcx;
    logic [YW-1:0] ncy, tcy;
    logic [XW:0]   xs;
    logic [YW:0]   ys;

`ifdef DRAW_SCHED_ROUND_ROBIN_EN
    logic [2:0] ptr;
    logic [2:0] cand;
    logic       found;

    // Search upward from the requester after the last winner, wrapping 7->0.
    always_comb begin
        win   = 3'd0;
        cand  = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
`else
    // Lowest set index wins.
    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) win = 3'(i);
        end
    end
`endif

    // Next raster position and the pixel that will be presented at the coming edge.
    always_comb begin
        col_end = (cx == w - 8'd1);
        last    = col_end && (cy == h - 7'd1);
        ncx     = col_end ? 8'd0 : cx + 8'd1;
        ncy     = col_end ? cy + 7'd1 : cy;
        tcx     = (state == SCAN) ? ncx : 8'd0;
        tcy     = (state == SCAN) ? ncy : 7'd0;
        xs      = {1'b0, ox} + {1'b0, tcx};
        ys      = {1'b0, oy} + {1'b0, tcy};
        vis     = (xs < {1'b0, SCR_W}) && (ys < {1'b0, SCR_H});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            gnt    <= 8'd0;
            done   <= 8'd0;
            busy   <= 1'b0;
            plot   <= 1'b0;
            x_data <= 8'd0;
            y_data <= 7'd0;
            ox     <= 8'd0;
            oy     <= 7'd0;
            w      <= 8'd0;
            h      <= 7'd0;
            cx     <= 8'd0;
            cy     <= 7'd0;
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
            ptr    <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 8'd1 << win;
                        busy  <= 1'b1;
                        cx    <= 8'd0;
                        cy    <= 7'd0;
`ifdef DRAW_SCHED_ROUND_ROBIN_EN
                        ptr   <= win;
`endif
                        // Requesters 0 and 1 always paint the whole screen from the corner.
                        if (win < 3'd2) begin
                            ox <= 8'd0;
                            oy <= 7'd0;
                            w  <= SCR_W;
                            h  <= SCR_H;
                        end else begin
                            ox <= org_x;
                            oy <= org_y;
                            w  <= SPRITE_W;
                            h  <= SPRITE_H;
                        end
                    end
                end
                GRANT: begin
                    state  <= SCAN;
                    plot   <= vis;
                    x_data <= xs[XW-1:0];
                    y_data <= ys[YW-1:0];
                end
                SCAN: begin
                    if (last) begin
                        state <= DONE;
                        plot  <= 1'b0;
                        done  <= gnt;
                    end else begin
                        cx     <= ncx;
                        cy     <= ncy;
                        plot   <= vis;
                        x_data <= xs[XW-1:0];
                        y_data <= ys[YW-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 8'd0;
                    busy  <= 1'b0;
                    gnt   <= 8'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: every busy cycle is checked against a queue of
// expected cycles built from an independent raster model when each request is raised.
module tb_draw_scheduler;

    localparam int SPR_W  = 32;
    localparam int SPR_H  = 32;
    localparam int BUDGET = 25000;

    logic       clk;
    logic       resetn;
    logic [7:0] req;
    logic [7:0] org_x;
    logic [6:0] org_y;
    logic [7:0] gnt;
    logic       busy;
    logic       plot;
    logic [7:0] x_data;
    logic [6:0] y_data;
    logic [7:0] done;

    typedef struct packed {
        logic [7:0] gnt;
        logic [7:0] done;
        logic       plot;
        logic       chk;
        logic [7:0] x;
        logic [6:0] y;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    int   nplot = 0;

    draw_scheduler #(.SPRITE_W(8'd32), .SPRITE_H(7'd32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .org_x  (org_x),
        .org_y  (org_y),
        .gnt    (gnt),
        .busy   (busy),
        .plot   (plot),
        .x_data (x_data),
        .y_data (y_data),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs of one draw: GRANT, W*H scan pixels, DONE.
    task automatic push_draw(input int idx, input int ox, input int oy);
        exp_t e;
        int w, h, bx, by, sx, sy;
        bit full;
        full = (idx < 2);
        w  = full ? 160 : SPR_W;
        h  = full ? 120 : SPR_H;
        bx = full ? 0 : ox;
        by = full ? 0 : oy;
        e = '0;
        e.gnt = 8'(1 << idx);
        sb.push_back(e);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                sx = bx + x;
                sy = by + y;
                e.plot = (sx < 160) && (sy < 120);
                e.chk  = 1'b1;
                e.x    = 8'(sx);
                e.y    = 7'(sy);
                sb.push_back(e);
            end
        end
        e.plot = 1'b0;
        e.chk  = 1'b0;
        e.x    = 8'd0;
        e.y    = 7'd0;
        e.done = e.gnt;
        sb.push_back(e);
    endtask

    // One cycle: compare a busy cycle against the scoreboard; requesters drop req on done.
    task automatic tick();
        @(negedge clk);
        if (resetn && busy) begin
            if (sb.size() == 0) begin
                check("extra_busy_cycle", 32'(busy), 32'd0);
            end else begin
                cur = sb.pop_front();
                check("cycle_gnt_done_plot", 32'({gnt, done, plot}), 32'({cur.gnt, cur.done, cur.plot}));
                if (cur.chk) check("cycle_xy", 32'({x_data, y_data}), 32'({cur.x, cur.y}));
                if (plot) nplot++;
            end
        end
        if (|done) req = req & ~done;
    endtask

    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < BUDGET) begin
            tick();
            n++;
        end
        check({tag, "_finished_in_budget"}, 32'(n < BUDGET), 32'd1);
        check({tag, "_gnt_idle"}, 32'(gnt), 32'd0);
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0;
        req    = 8'h00;
        org_x  = 8'd0;
        org_y  = 7'd0;
        repeat (2) @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_xy", 32'({x_data, y_data}), 32'd0);
        resetn = 1'b1;
        tick();

        // Sprite at (10,20); origin inputs scrambled once the draw is under way.
        org_x = 8'd10; org_y = 7'd20; req = 8'h04;
        push_draw(2, 10, 20);
        nplot = 0;
        repeat (3) tick();
        org_x = 8'd99; org_y = 7'd99;
        run_until_idle("sprite_10_20");
        check("sprite_10_20_plots", 32'(nplot), 32'd1024);

        // Sprite clipped at the bottom-right corner.
        org_x = 8'd150; org_y = 7'd110; req = 8'h08;
        push_draw(3, 150, 110);
        nplot = 0;
        run_until_idle("sprite_clip");
        check("sprite_clip_plots", 32'(nplot), 32'd100);

        // Full-screen draw ignores the origin inputs.
        org_x = 8'd77; org_y = 7'd55; req = 8'h01;
        push_draw(0, 0, 0);
        nplot = 0;
        run_until_idle("full_screen");
        check("full_screen_plots", 32'(nplot), 32'd19200);

        // Simultaneous sprite requests, twice.
        org_x = 8'd5; org_y = 7'd6; req = 8'h0C;
        push_draw(2, 5, 6);
        push_draw(3, 5, 6);
        run_until_idle("pair_a");
        req = 8'h0C;
        push_draw(2, 5, 6);
        push_draw(3, 5, 6);
        run_until_idle("pair_b");

        // Reset in the middle of a scan abandons the draw.
        org_x = 8'd1; org_y = 7'd2; req = 8'h20;
        push_draw(5, 1, 2);
        repeat (40) tick();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        req    = 8'h00;
        #1;
        check("midreset_gnt", 32'(gnt), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_plot", 32'(plot), 32'd0);
        check("midreset_xy", 32'({x_data, y_data}), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        sb.delete();
        repeat (3) begin
            tick();
            check("midreset_no_done", 32'(done), 32'd0);
        end
        resetn = 1'b1;
        req    = 8'h20;
        push_draw(5, 1, 2);
        run_until_idle("after_reset");

        // Requester drops req mid-scan while a full-screen request arrives.
        org_x = 8'd30; org_y = 7'd40; req = 8'h04;
        push_draw(2, 30, 40);
        push_draw(1, 0, 0);
        repeat (6) tick();
        req = 8'h02;
        run_until_idle("drop_and_queue");

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: SPRITE_W, 8'd32, sprite draw width in pixels (1..160).
REQ-002 Parameter: SPRITE_H, 7'd32, sprite draw height in pixels (1..120).
REQ-003 Port: clk  input  1  sole clock; all logic rising-edge.
REQ-004 Port: resetn  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  8  draw requests, one bit per requester; bits 0-1 are full-screen, bits 2-7 are sprite.
REQ-006 Port: org_x  input  8  sprite origin X, sampled at grant.
REQ-007 Port: org_y  input  7  sprite origin Y, sampled at grant.
REQ-008 Port: gnt  output  8  one-hot grant, held for the whole draw.
REQ-009 Port: busy  output  1  high from grant cycle through done cycle.
REQ-010 Port: plot  output  1  pixel write strobe to VGA adapter.
REQ-011 Port: x_data  output  8  pixel X.
REQ-012 Port: y_data  output  7  pixel Y.
REQ-013 Port: done  output  8  one-cycle completion pulse for the granted requester.

Function
REQ-014 FSM states SHALL be IDLE, GRANT, SCAN, DONE.
REQ-015 IDLE: any req bit high -> GRANT next edge; winner is the lowest set index; gnt registered one-hot.
REQ-016 GRANT (1 cycle): latch origin (org_x/org_y for bits 2-7; forced 0,0 for bits 0-1); load region W,H (160x120 full-screen, SPRITE_W x SPRITE_H sprite); clear column/row counters cx, cy; plot=0.
REQ-017 SCAN: one pixel per cycle, raster order; x_data = ox+cx, y_data = oy+cy.
REQ-018 cx increments to W-1, then wraps to 0 while cy increments; the pixel at (W-1,H-1) is the last pixel.
REQ-019 Latency: req high in IDLE -> first plot at the 2nd edge after sampling; a draw occupies exactly 1+W*H+1 cycles (GRANT+SCAN+DONE).
REQ-020 Clipping: if ox+cx >= 160 (9-bit sum) or oy+cy >= 120 (8-bit sum), plot=0 for that pixel; counters still advance. x_data/y_data carry the low 8/7 sum bits.
REQ-021 DONE (1 cycle): done[g]=1, plot=0, busy=1; gnt cleared at next edge; return to IDLE.
REQ-022 Non-preemptive: new or higher-priority requests during GRANT/SCAN/DONE are ignored until IDLE.
REQ-023 Requester dropping req mid-draw SHALL NOT abort the draw; done still pulses.
REQ-024 req still high in IDLE after its done SHALL be re-arbitrated normally (requester must drop req on done).
REQ-025 org_x/org_y changes after GRANT SHALL NOT affect the current draw.
REQ-026 gnt, done SHALL never have more than one bit set.

Reset
REQ-027 resetn low SHALL asynchronously force state IDLE and gnt=0, done=0, busy=0, plot=0, x_data=0, y_data=0, cx=cy=0, round-robin pointer=0.
REQ-028 Reset mid-draw SHALL abandon the draw with no done pulse; first arbitration follows the first edge after resetn rises.

Configuration
REQ-029 Macro DRAW_SCHED_ROUND_ROBIN_EN defined: arbitration SHALL be round-robin, searching upward (wrapping 7->0) from the index after the last granted requester; pointer updates on GRANT.
REQ-030 Macro undefined: fixed priority per REQ-015; no pointer register is built.

Verification
REQ-031 req=8'h04, org=(10,20), SPRITE 32x32 -> first plot (10,20) two edges later, last plot (41,51), done=8'h04 exactly 1026 cycles after GRANT.
REQ-032 req=8'h01 -> 19200 plots (0,0)..(159,119), all plot=1, done=8'h01 single cycle.
REQ-033 org=(150,110), sprite 32x32 -> plot=1 only for x<160, y<120 (100 pixels); done still at cycle 1026.
REQ-034 req=8'h0C simultaneous -> fixed: bit2 then bit3; with DRAW_SCHED_ROUND_ROBIN_EN, after bit3 granted and req=8'h0C again, bit2 wins next.
REQ-035 resetn low mid-SCAN -> all outputs 0 immediately, no done; req=8'h20 after release -> normal draw.
REQ-036 req=8'h04 dropped at cycle 5 of SCAN and req=8'h02 raised -> sprite completes, done=8'h04, then gnt=8'h02.
